// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop input synchroniser,
// mid-bit sampling and a one-entry valid/ready holding register.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   rx              - asynchronous serial input, idles high
//   rx_data/valid   - received byte and holding-register-full flag
//   rx_ready        - consumer takes rx_data when rx_valid && rx_ready
//   frame_err       - one-cycle pulse, stop bit sampled low
//   overrun         - one-cycle pulse, good byte dropped (register busy)
module uart_rx #(
  parameter int unsigned PERIOD = 27_000_000 / 9600,
  parameter int unsigned BITS   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  // START is entered the cycle after the falling edge is seen, so the
  // counter reads one less than the elapsed cycle count at mid-bit.
  localparam logic [BITS-1:0] HALF_M1 = BITS'((PERIOD >> 1) - 1);
  localparam logic [BITS-1:0] LAST    = BITS'(PERIOD - 1);

  state_e          state_q;
  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;
  logic [2:0]      bit_idx_q;
  logic [7:0]      sh_q;
  logic            s1_q;
  logic            rxs_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ferr_q;
  logic            ovr_q;

  assign cnt_d = cnt_q + BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      s1_q   <= rx;
      rxs_q  <= s1_q;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= cnt_d;
      // Consume; a delivery below in the same cycle overrides this.
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q     <= '0;
            sh_q      <= {rxs_q, sh_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= IDLE;
              if (!valid_q || rx_ready) begin
                data_q  <= sh_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not look like new start bits.
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
